// File: rtl/dot_product_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : dot_product_feeder_if
// Description : Vector-pair input, engine-side serial link and result port
//               of the dot-product feeder.
// Revision    : 1.0
// ============================================================================
interface dot_product_feeder_if #(
    parameter int VEC_WIDTH = 64,
    parameter int RES_WIDTH = 19
);
    logic                 in_valid;
    logic                 in_ready;
    logic [VEC_WIDTH-1:0] in_a;
    logic [VEC_WIDTH-1:0] in_b;
    logic                 Start;
    logic                 SerialData;
    logic                 Done;
    logic [RES_WIDTH-1:0] DataOut;
    logic                 res_valid;
    logic                 res_ready;
    logic [RES_WIDTH-1:0] res_data;
    logic                 res_err;

    modport slave (
        input  in_valid, in_a, in_b, Done, DataOut, res_ready,
        output in_ready, Start, SerialData, res_valid, res_data, res_err
    );

    modport master (
        output in_valid, in_a, in_b, Done, DataOut, res_ready,
        input  in_ready, Start, SerialData, res_valid, res_data, res_err
    );
endinterface
`default_nettype wire

// File: rtl/dot_product_feeder.sv
`default_nettype none
// ============================================================================
// Module      : dot_product_feeder
// Description : Serialises a vector pair LSB-first to the dot-product engine
//               and returns its result, with a watchdog for a missing Done.
// Revision    : 1.0
// ============================================================================
module dot_product_feeder #(
    parameter int VEC_WIDTH = 64,
    parameter int RES_WIDTH = 19,
    parameter int TIMEOUT   = 16
) (
    input  wire logic        clk,
    input  wire logic        Reset,
    dot_product_feeder_if.slave bus
);
    localparam int                 c_CNT_W    = (VEC_WIDTH > 1) ? $clog2(VEC_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(VEC_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [7:0]         c_TIMEOUT  = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        SEND_A    = 3'd2,
        SEND_B    = 3'd3,
        WAIT_DONE = 3'd4,
        RESULT    = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [VEC_WIDTH-1:0] r_a_sh;
    logic [VEC_WIDTH-1:0] r_b_sh;
    logic [c_CNT_W-1:0]   r_bit_cnt;
    logic [7:0]           r_wd_cnt;
    logic [RES_WIDTH-1:0] r_res_data;
    logic                 r_res_err;
    logic                 r_in_ready;
    logic                 w_accept;
    logic                 w_cnt_last;
    logic                 w_timeout;
    logic                 w_start;
    logic                 w_serial;

    assign w_accept   = bus.in_valid & r_in_ready;
    assign w_cnt_last = (r_bit_cnt == c_CNT_LAST);
    assign w_timeout  = (r_wd_cnt >= c_TIMEOUT);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Start/SerialData depend only on the state register and shift-register LSBs
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_serial    = 1'b0;
        case (r_state)
            IDLE:      if (w_accept) w_state_nxt = START;
            START: begin
                w_start     = 1'b1;
                w_state_nxt = SEND_A;
            end
            SEND_A: begin
                w_serial = r_a_sh[0];
                if (w_cnt_last) w_state_nxt = SEND_B;
            end
            SEND_B: begin
                w_serial = r_b_sh[0];
                if (w_cnt_last) w_state_nxt = WAIT_DONE;
            end
            WAIT_DONE: if (bus.Done || w_timeout) w_state_nxt = RESULT;
            RESULT:    if (bus.res_ready) w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_bit_cnt  <= '0;
            r_wd_cnt   <= '0;
            r_res_data <= '0;
            r_res_err  <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            // Registered so that in_ready stays low while Reset is asserted
            r_in_ready <= (w_state_nxt == IDLE);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a_sh    <= bus.in_a;
                        r_b_sh    <= bus.in_b;
                        r_bit_cnt <= '0;
                    end
                end
                SEND_A: begin
                    r_a_sh    <= r_a_sh >> 1;
                    r_bit_cnt <= w_cnt_last ? '0 : r_bit_cnt + c_CNT_ONE;
                end
                SEND_B: begin
                    r_b_sh    <= r_b_sh >> 1;
                    r_bit_cnt <= w_cnt_last ? '0 : r_bit_cnt + c_CNT_ONE;
                    if (w_cnt_last) r_wd_cnt <= '0;
                end
                WAIT_DONE: begin
                    // Done takes priority over a coincident timeout
                    if (bus.Done) begin
                        r_res_data <= bus.DataOut;
                        r_res_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_res_data <= '0;
                        r_res_err  <= 1'b1;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.Start      = w_start;
    assign bus.SerialData = w_serial;
    assign bus.res_valid  = (r_state == RESULT);
    assign bus.res_data   = r_res_data;
    assign bus.res_err    = r_res_err;

endmodule
`default_nettype wire

// File: doc/dot_product_feeder.md
# dot_product_feeder

Upstream front-end for the serial dot-product engine. Accepts a pair of 64-bit vectors over a parallel valid/ready handshake, each vector holding eight unsigned 8-bit elements with element 0 in bits [7:0]. Generates the engine's one-cycle `Start` pulse and the 128-bit LSB-first `SerialData` stream. Captures the engine's 19-bit result on `Done` and returns it over a valid/ready result port, with a watchdog for a missing `Done`.

## Interface
- `VEC_WIDTH`, default 64: bits per vector; the serial count per vector equals this value.
- `RES_WIDTH`, default 19: result width; must match the engine's `DataOut`.
- `TIMEOUT`, default 16: maximum `WAIT_DONE` cycles before the watchdog fires; range 1..255.
- `clk`  in  1  clock; all logic is on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  vector pair offered.
- `in_ready`  out  1  feeder can accept a vector pair.
- `in_a`  in  VEC_WIDTH  vector A.
- `in_b`  in  VEC_WIDTH  vector B.
- `Start`  out  1  one-cycle start pulse to the engine.
- `SerialData`  out  1  serial bit to the engine.
- `Done`  in  1  engine result strobe.
- `DataOut`  in  RES_WIDTH  engine result; valid only while `Done`=1.
- `res_valid`  out  1  result held for the consumer.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  RES_WIDTH  captured result.
- `res_err`  out  1  result came from a watchdog timeout.

## Operation
- States: `IDLE`, `START`, `SEND_A`, `SEND_B`, `WAIT_DONE`, `RESULT`.
- `IDLE`
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, load `in_a`/`in_b` into the shift registers `a_sh`/`b_sh`, clear the bit counter, and go to `START`.
- `START`
  - `Start`=1 for exactly this cycle.
  - Go to `SEND_A`.
- `SEND_A`
  - `SerialData`=`a_sh[0]`; `a_sh` shifts right by 1 each cycle.
  - After VEC_WIDTH cycles (counter wraps VEC_WIDTH-1→0), go to `SEND_B`.
- `SEND_B`
  - Same as `SEND_A` using `b_sh`.
  - After VEC_WIDTH cycles, go to `WAIT_DONE` and clear the watchdog counter.
- `WAIT_DONE`
  - If `Done`=1: `res_data`←`DataOut`, `res_err`←0, go to `RESULT`.
  - Else, once the watchdog counter has reached TIMEOUT cycles: `res_data`←0, `res_err`←1, go to `RESULT`.
  - `Done` and timeout in the same cycle: `Done` wins.
- `RESULT`
  - `res_valid`=1; `res_data`/`res_err` hold stable.
  - On `res_ready`=1, go to `IDLE`.
- `Done` outside `WAIT_DONE` is ignored.
- `in_ready`=0 in every state except `IDLE`; no overlap of transactions.
- `SerialData`=0 in all states except `SEND_A` and `SEND_B`.
- `Start` and `SerialData` are decoded only from the state register and the shift-register LSB (no input-to-output combinational path).
- Arithmetic: the feeder does no arithmetic on the result; `res_data` is a straight capture, zero-extended never truncated. Maximum legal value is 8·255² = 520200, which fits in 19 bits.

## Timing
- Reset values: `in_ready`=0 during reset and 1 from the first cycle after release; `Start`=0; `SerialData`=0; `res_valid`=0; `res_data`=0; `res_err`=0; state=`IDLE`; shift registers and counters =0.
- Handshake accepted at cycle T. `Start` is high at T+1.
- A bit i is driven at T+2+i; B bit i at T+66+i (VEC_WIDTH=64).
- `WAIT_DONE` is entered at T+130. The engine pulses `Done` at T+135.
- `res_valid` rises at T+136 and is registered (no same-cycle bypass).
- If `res_ready`=1 at T+136, `in_ready` returns at T+137. Best-case throughput is one pair per 137 cycles.
- Timeout fires at cycle T+130+TIMEOUT with no `Done`.
- Reset mid-operation (any state): return immediately to reset values. Any partially sent stream is abandoned; the engine shares `Reset`, so both restart clean.

## Test plan
- A=0x0807060504030201, B=0x0101010101010101 → `Start` at T+1; `SerialData` at T+2..T+9 = 1,0,0,0,0,0,0,0; `res_data`=36, `res_err`=0 at T+136.
- A=B=0xFFFF_FFFF_FFFF_FFFF, with `res_ready` held 0 for 10 cycles → `res_data`=520200 (0x7F008) held stable with `res_valid`=1 until `res_ready`; `in_ready` stays 0 throughout.
- Engine stubbed to never assert `Done`, TIMEOUT=16 → `res_valid`=1, `res_err`=1, `res_data`=0 at T+147.
- `in_valid` asserted continuously with back-to-back pairs (A=1,B=1 then A=2,B=3, both element 0 only), `res_ready`=1 → results 1 then 6; the second accept occurs exactly at T+137; stray `Done` pulses during `SEND_A` are injected and ignored.
- `Reset` pulsed at T+40 (mid `SEND_A`) → `Start`/`SerialData`/`res_valid`=0 immediately; `in_ready`=1 the cycle after release; a new pair (A=B=0x0101010101010101) then completes with `res_data`=8.
